// File: rtl/dice_roll_if.sv
// Signal bundle between the roll front end, the dice generator and the game FSM.
//
// Handshake: result_valid rises when a roll completes and stays high, with all
// result fields stable, until the consumer raises result_ack. The controller
// leaves DONE on the edge that samples result_ack high, so result_valid is low
// from that edge onward. result_ack while result_valid is low has no effect.
interface dice_roll_if;
    logic       roll_req;
    logic [2:0] die_value;
    logic       result_ack;
    logic       busy;
    logic       result_valid;
    logic [2:0] die_a;
    logic [2:0] die_b;
    logic [3:0] sum;
    logic       is_double;
    logic       has_three;
    logic       timeout_err;

    // Requester / consumer side.
    modport master (
        output roll_req, die_value, result_ack,
        input  busy, result_valid, die_a, die_b, sum, is_double, has_three, timeout_err
    );

    // Controller side.
    modport slave (
        input  roll_req, die_value, result_ack,
        output busy, result_valid, die_a, die_b, sum, is_double, has_three, timeout_err
    );
endinterface

// File: rtl/dice_roll_controller.sv
// Two-dice roll sequencer: samples the free-running generator for die A, waits a
// decorrelation gap, samples die B, then presents the result with derived flags
// until acknowledged. Out-of-range generator codes are skipped; a die that sees
// TIMEOUT invalid codes in a row is forced to 1 and flagged.
module dice_roll_controller #(
    parameter int GAP_CYCLES = 7,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    dice_roll_if.slave  bus,
    output logic [2:0]  o_dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SAMPLE_A = 3'd1;
    localparam logic [2:0] S_GAP      = 3'd2;
    localparam logic [2:0] S_SAMPLE_B = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        r_state;
    logic              r_roll_req_q;
    logic [WAIT_W-1:0] r_wait;
    logic [GAP_W-1:0]  r_gap;
    logic [2:0]        r_die_a;
    logic [2:0]        r_die_b;
    logic [3:0]        r_sum;
    logic              r_is_double;
    logic              r_has_three;
    logic              r_timeout_err;

    logic              w_start;
    logic              w_die_ok;
    logic              w_forced;
    logic              w_capture;
    logic [2:0]        w_die_cap;

    // Rising edge of the request, and what a sample phase would capture this cycle.
    assign w_start   = bus.roll_req & ~r_roll_req_q;
    assign w_die_ok  = (bus.die_value >= 3'd1) && (bus.die_value <= 3'd6);
    assign w_forced  = !w_die_ok && (r_wait == WAIT_LAST);
    assign w_capture = w_die_ok || w_forced;
    assign w_die_cap = w_die_ok ? bus.die_value : 3'd1;

    // Sequencer: state, counters and all registered result fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_roll_req_q  <= 1'b0;
            r_wait        <= '0;
            r_gap         <= '0;
            r_die_a       <= 3'd0;
            r_die_b       <= 3'd0;
            r_sum         <= 4'd0;
            r_is_double   <= 1'b0;
            r_has_three   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_roll_req_q <= bus.roll_req;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state       <= S_SAMPLE_A;
                        r_wait        <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_SAMPLE_A: begin
                    if (w_capture) begin
                        r_die_a <= w_die_cap;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                        if (w_forced) r_timeout_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_wait  <= '0;
                        r_state <= S_SAMPLE_B;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_SAMPLE_B: begin
                    if (w_capture) begin
                        r_die_b     <= w_die_cap;
                        r_sum       <= {1'b0, r_die_a} + {1'b0, w_die_cap};
                        r_is_double <= (r_die_a == w_die_cap);
                        r_has_three <= (r_die_a == 3'd3) || (w_die_cap == 3'd3);
                        r_state     <= S_DONE;
                        if (w_forced) r_timeout_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.result_ack) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.die_a        = r_die_a;
    assign bus.die_b        = r_die_b;
    assign bus.sum          = r_sum;
    assign bus.is_double    = r_is_double;
    assign bus.has_three    = r_has_three;
    assign bus.timeout_err  = r_timeout_err;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Bench for dice_roll_controller: directed edge cases plus randomized rolls,
// checked by a result scoreboard fed from a per-roll reference model.
module tb_dice_roll_controller;

    localparam int GAP = 7;
    localparam int TMO = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dice_roll_if bus();
    logic [2:0] dbg_state;

    dice_roll_controller #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: {die_a, die_b, sum, is_double, has_three, timeout_err}
    logic [12:0] exp_q[$];
    int          exp_cyc_q[$];

    int ncyc;
    int hold_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [12:0] actual_result();
        return {bus.die_a, bus.die_b, bus.sum, bus.is_double, bus.has_three, bus.timeout_err};
    endfunction

    function automatic logic [2:0] inv_code();
        return ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle step; releases roll_req once its hold time has elapsed.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (ncyc >= hold_len) bus.roll_req = 1'b0;
    endtask

    // A complete roll. ninv_x = invalid codes shown before the good value
    // (>= TMO means the die is forced). The model: a die costs ninv+1 sample
    // cycles, or TMO cycles when forced to 1; the gap costs GAP cycles.
    task automatic do_roll(input logic [2:0] a, input logic [2:0] b,
                           input int ninv_a, input int ninv_b, input int hold,
                           input int ack_delay, input bit gap_pulse, input bit ack_edge);
        bit          fa, fb;
        int          ca, cb, c0, w;
        logic [2:0]  va, vb;
        logic [3:0]  s;
        logic [2:0]  seq[$];
        fa = (ninv_a >= TMO);
        fb = (ninv_b >= TMO);
        ca = fa ? TMO : ninv_a + 1;
        cb = fb ? TMO : ninv_b + 1;
        va = fa ? 3'd1 : a;
        vb = fb ? 3'd1 : b;
        s  = {1'b0, va} + {1'b0, vb};
        for (int k = 0; k < ca; k++) seq.push_back((k < ninv_a) ? inv_code() : a);
        for (int k = 0; k < GAP; k++) seq.push_back(3'($urandom_range(0, 7)));
        for (int k = 0; k < cb; k++) seq.push_back((k < ninv_b) ? inv_code() : b);

        @(negedge clk);
        bus.roll_req  = 1'b1;
        bus.die_value = 3'($urandom_range(0, 7));
        hold_len      = hold;
        ncyc          = 0;
        @(negedge clk);
        c0 = cyc;
        exp_q.push_back({va, vb, s, va == vb, (va == 3'd3) || (vb == 3'd3), fa | fb});
        exp_cyc_q.push_back(c0 + ca + GAP + cb);

        for (int i = 0; i < seq.size(); i++) begin
            bus.die_value = seq[i];
            if (gap_pulse && i == ca + 2) bus.roll_req = 1'b1;
            tick();
        end
        bus.die_value = 3'($urandom_range(0, 7));

        w = 0;
        while (!bus.result_valid && w < 50) begin
            tick();
            w++;
        end
        check("result_arrives", {31'd0, bus.result_valid}, 32'd1);

        repeat (ack_delay) tick();
        bus.result_ack = 1'b1;
        if (ack_edge) begin
            bus.roll_req = 1'b1;
            hold_len     = ncyc + 6;
        end
        tick();
        bus.result_ack = 1'b0;
        check("valid_drop_on_ack", {31'd0, bus.result_valid}, 32'd0);
        check("busy_drop_on_ack", {31'd0, bus.busy}, 32'd0);

        while (ncyc < hold_len + 2) begin
            tick();
            check("idle_no_restart", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          prev_v = 1'b0;
        bit          have   = 1'b0;
        logic [12:0] cur    = '0;
        int          ec;
        forever begin
            @(negedge clk);
            if (!rst && bus.result_valid) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        have = 1'b0;
                        $display("FAIL unexpected_result at cycle %0d: got 0x%0h, expected no result",
                                 cyc, actual_result());
                    end else begin
                        cur  = exp_q.pop_front();
                        ec   = exp_cyc_q.pop_front();
                        have = 1'b1;
                        check("result_latency", cyc, ec);
                    end
                end
                if (have) check("result_fields", {19'd0, actual_result()}, {19'd0, cur});
                check("busy_in_done", {31'd0, bus.busy}, 32'd1);
            end
            prev_v = bus.result_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        bus.roll_req   = 1'b0;
        bus.die_value  = 3'd0;
        bus.result_ack = 1'b0;
        ncyc           = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_results", {19'd0, actual_result()}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // normal roll, result held 20 cycles before ack
        do_roll(3'd4, 3'd2, 0, 0, 1, 20, 1'b0, 1'b0);
        // invalid codes skipped, double three
        do_roll(3'd3, 3'd3, 3, 3, 1, 1, 1'b0, 1'b0);
        // both dice forced, then a clean roll clears timeout_err
        do_roll(3'd5, 3'd6, 40, 40, 1, 2, 1'b0, 1'b0);
        do_roll(3'd6, 3'd1, 0, 0, 1, 0, 1'b0, 1'b0);
        // timeout boundary: 14 invalid still captures, 15 forces
        do_roll(3'd2, 3'd5, 14, 15, 1, 1, 1'b0, 1'b0);
        // request held high for 50 cycles: exactly one roll
        do_roll(3'd1, 3'd6, 0, 1, 50, 0, 1'b0, 1'b0);
        // second pulse during GAP is ignored
        do_roll(3'd6, 3'd6, 1, 0, 1, 0, 1'b1, 1'b0);
        // request edge coinciding with ack is ignored
        do_roll(3'd5, 3'd3, 0, 2, 1, 3, 1'b0, 1'b1);

        // reset in the middle of GAP discards the roll
        @(negedge clk);
        bus.roll_req  = 1'b1;
        bus.die_value = 3'd5;
        hold_len      = 1;
        ncyc          = 0;
        @(negedge clk);
        tick();
        tick();
        tick();
        check("gap_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midgap_reset_results", {19'd0, actual_result()}, 32'd0);
        check("midgap_reset_busy", {31'd0, bus.busy}, 32'd0);
        check("midgap_reset_valid", {31'd0, bus.result_valid}, 32'd0);
        repeat (12) begin
            tick();
            check("after_reset_idle", {31'd0, bus.busy}, 32'd0);
        end

        // randomized rolls
        for (int r = 0; r < 200; r++) begin
            logic [2:0] a, b;
            int na, nb;
            a  = 3'($urandom_range(1, 6));
            b  = 3'($urandom_range(1, 6));
            na = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 3));
            nb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 3));
            do_roll(a, b, na, nb, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
